ps2_host_cmd_ctrl: RTL and testbench
====================================

Name: ps2_host_cmd_ctrl

Overview:
- Host-side controller for the PS/2 keyboard port: sends one-byte device commands (e.g. 0xED LED set, 0xFF reset) using the host-to-device protocol.
- Waits for the device response (0xFA ACK / 0xFE resend) on the existing PS/2 receiver's output and retries on resend.
- Arbitrates the receiver output: scan events pass to the keyboard consumer only while no command is in flight.
- Sits between the PS/2 pads (open-drain enables), the PS/2 receiver (ready / 10-bit code) and the CPU-side command register.

Parameters:
- INHIBIT_CYC, 10000, clk cycles ps2 clock is held low before start (100 us at 100 MHz)
- TIMEOUT_CYC, 2000000, max clk cycles between protocol progress events (20 ms at 100 MHz)
- MAX_RETRY, 3, retransmissions allowed after 0xFE

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command byte offered
- cmd_byte  in  8  command to send
- cmd_ready  out  1  controller idle, accepts command
- ps2_clk_in  in  1  raw ps2 clock pad input
- ps2_data_in  in  1  raw ps2 data pad input
- ps2_clk_drive_low  out  1  1 = pull ps2 clock low, 0 = release
- ps2_data_drive_low  out  1  1 = pull ps2 data low, 0 = release
- rx_ready  in  1  receiver one-cycle done pulse
- rx_code  in  10  receiver {expand, break, byte}
- evt_valid  out  1  forwarded scan event pulse
- evt_code  out  10  forwarded scan event
- done  out  1  one-cycle pulse, command finished
- status  out  2  00 ok, 01 nak (retries exhausted), 10 timeout; valid with done and held
- busy  out  1  command in flight

Behaviour:
- Reset (async, rst_n=0): state IDLE; drive_low outputs 0 immediately (lines released); cmd_ready=1, busy=0, done=0, evt_valid=0, evt_code=0, status=00, retry count 0. Reset mid-transfer aborts silently, no done.
- ps2_clk_in: 4-stage shift register on clk; falling edge detected when the two newest samples are 0 and the two oldest are 1 (single-cycle pulse).
- Accept: cmd_valid & cmd_ready in IDLE latches cmd_byte, computes odd parity = ~^byte, clears retry count, enters INHIBIT next cycle. cmd_ready=1 only in IDLE; busy = ~IDLE.
- INHIBIT: clk_drive_low=1, data_drive_low=0 for exactly INHIBIT_CYC cycles -> START.
- START: data_drive_low=1 (start bit), clk_drive_low=0; wait for falling edge.
- TX_BITS: bit counter n counts falling edges 1..10. Edge n=1..8 presents data bit n-1 (LSB first), n=9 parity, n=10 stop (data released). data_drive_low = ~bit. After edge 10 -> ACK_WAIT.
- ACK_WAIT: on next falling edge sample synchronized data one clk after the edge. Low -> RESP_WAIT; high -> treated as 0xFE (retry path).
- RESP_WAIT: wait rx_ready. rx_code[7:0]==0xFA -> DONE status 00. ==0xFE -> if retry<MAX_RETRY, retry++ and INHIBIT (same byte) else DONE status 01. Any other byte is discarded and waiting continues.
- DONE: one cycle, done=1, -> IDLE.
- Timeout: watchdog reset on state entry and each falling edge; active in START, TX_BITS, ACK_WAIT, RESP_WAIT. Reaching TIMEOUT_CYC releases both lines -> DONE status 10.
- Event arbitration: evt_valid = rx_ready registered when state==IDLE, evt_code captures rx_code the same cycle (1-cycle latency). rx_ready in any other state is consumed, never forwarded. A rx_ready coinciding with command acceptance is forwarded (state still IDLE).
- Both lines are released in IDLE and DONE; never both driven low simultaneously outside START and TX_BITS.

Test Plan:
- cmd 0xED; device model clocks 11 edges, ACKs, returns 0xFA -> data bits 1,0,1,1,0,1,1,1, parity 1, stop released; done with status 00; clk low INHIBIT_CYC cycles beforehand.
- cmd 0xFF; device answers 0xFE twice then 0xFA -> 3 full transmissions of 0xFF, status 00.
- MAX_RETRY=3; device always answers 0xFE -> 4 transmissions, done status 01.
- Device never clocks after START -> lines released and done status 10 exactly TIMEOUT_CYC cycles after START entry.
- IDLE rx_ready with rx_code 0x01C -> evt_valid one cycle, evt_code 0x01C; same pulse during RESP_WAIT (e.g. 0x21C) -> no evt_valid.
- rst_n low during TX_BITS bit 4 -> both drive_low 0 with no clk edge; cmd_ready=1, no done after release.

Source files
------------

// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host-side command controller: sends one command byte with the
// host-to-device protocol, waits for ACK/resend, and gates scan events while busy.
module ps2_host_cmd_ctrl #(
  parameter int unsigned INHIBIT_CYC = 10000,
  parameter int unsigned TIMEOUT_CYC = 2000000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  input  logic       rx_ready,
  input  logic [9:0] rx_code,
  output logic       evt_valid,
  output logic [9:0] evt_code,
  output logic       done,
  output logic [1:0] status,
  output logic       busy
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_TX_BITS, S_ACK_WAIT, S_RESP_WAIT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         bitn_q, bitn_d;
  logic [7:0]         byte_q, byte_d;
  logic               par_q, par_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [1:0]         status_q, status_d;
  logic               ack_smp_q, ack_smp_d;
  logic [3:0]         clk_sr_q, clk_sr_d;
  logic [1:0]         dat_sr_q, dat_sr_d;
  logic               evt_valid_q, evt_valid_d;
  logic [9:0]         evt_code_q, evt_code_d;

  logic fall, tmo, wd_active, cur_bit;

  assign fall      = (clk_sr_q == 4'b1100);
  assign tmo       = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign wd_active = (state_q == S_START) || (state_q == S_TX_BITS) ||
                     (state_q == S_ACK_WAIT) || (state_q == S_RESP_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bitn_q      <= '0;
      byte_q      <= '0;
      par_q       <= 1'b0;
      retry_q     <= '0;
      status_q    <= '0;
      ack_smp_q   <= 1'b0;
      clk_sr_q    <= '1;
      dat_sr_q    <= '1;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitn_q      <= bitn_d;
      byte_q      <= byte_d;
      par_q       <= par_d;
      retry_q     <= retry_d;
      status_q    <= status_d;
      ack_smp_q   <= ack_smp_d;
      clk_sr_q    <= clk_sr_d;
      dat_sr_q    <= dat_sr_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitn_d      = bitn_q;
    byte_d      = byte_q;
    par_d       = par_q;
    retry_d     = retry_q;
    status_d    = status_q;
    ack_smp_d   = 1'b0;
    clk_sr_d    = {clk_sr_q[2:0], ps2_clk_in};
    dat_sr_d    = {dat_sr_q[0], ps2_data_in};
    evt_valid_d = rx_ready && (state_q == S_IDLE);
    evt_code_d  = (rx_ready && (state_q == S_IDLE)) ? rx_code : evt_code_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          byte_d  = cmd_byte;
          par_d   = ~^cmd_byte;
          retry_d = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) state_d = S_START;
      end
      S_START: begin
        if (fall) begin
          bitn_d  = 4'd1;
          state_d = S_TX_BITS;
        end else if (tmo) begin
          status_d = 2'b10;
          state_d  = S_DONE;
        end
      end
      S_TX_BITS: begin
        if (fall) begin
          // Edge 10 presents the stop bit, which is simply the released line.
          if (bitn_q == 4'd9) state_d = S_ACK_WAIT;
          else                bitn_d  = bitn_q + 4'd1;
        end else if (tmo) begin
          status_d = 2'b10;
          state_d  = S_DONE;
        end
      end
      S_ACK_WAIT: begin
        if (ack_smp_q) begin
          if (!dat_sr_q[1])                 state_d = S_RESP_WAIT;
          else if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = S_INHIBIT;
          end else begin
            status_d = 2'b01;
            state_d  = S_DONE;
          end
        end else if (fall) begin
          ack_smp_d = 1'b1;
        end else if (tmo) begin
          status_d = 2'b10;
          state_d  = S_DONE;
        end
      end
      S_RESP_WAIT: begin
        if (rx_ready && (rx_code[7:0] == 8'hFA)) begin
          status_d = 2'b00;
          state_d  = S_DONE;
        end else if (rx_ready && (rx_code[7:0] == 8'hFE)) begin
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = S_INHIBIT;
          end else begin
            status_d = 2'b01;
            state_d  = S_DONE;
          end
        end else if (tmo) begin
          status_d = 2'b10;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // One counter serves both the inhibit timer and the progress watchdog.
    if (state_d != state_q)                 cnt_d = '0;
    else if (state_q == S_INHIBIT)          cnt_d = cnt_q + 1'b1;
    else if (wd_active && !fall)            cnt_d = cnt_q + 1'b1;
    else                                    cnt_d = '0;
  end

  always_comb begin
    cur_bit            = (bitn_q == 4'd9) ? par_q : byte_q[bitn_q[2:0] - 3'd1];
    cmd_ready          = (state_q == S_IDLE);
    busy               = (state_q != S_IDLE);
    done               = (state_q == S_DONE);
    ps2_clk_drive_low  = (state_q == S_INHIBIT);
    ps2_data_drive_low = 1'b0;
    if (state_q == S_START)        ps2_data_drive_low = 1'b1;
    else if (state_q == S_TX_BITS) ps2_data_drive_low = ~cur_bit;
    status             = status_q;
    evt_valid          = evt_valid_q;
    evt_code           = evt_code_q;
  end

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Bench for ps2_host_cmd_ctrl: open-drain pad model, PS/2 device model and
// scoreboard queues for frames, completion status and forwarded events.
module tb_ps2_host_cmd_ctrl;
  localparam int unsigned INH  = 16;
  localparam int unsigned TMO  = 400;
  localparam int unsigned RTY  = 3;
  localparam int unsigned HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_byte = '0;
  logic       cmd_ready;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_drive_low, ps2_data_drive_low;
  logic       rx_ready = 1'b0;
  logic [9:0] rx_code = '0;
  logic       evt_valid;
  logic [9:0] evt_code;
  logic       done;
  logic [1:0] status;
  logic       busy;

  logic dev_clk_hi = 1'b1;
  logic dev_data_low = 1'b0;

  int tests = 0;
  int fails = 0;
  int inh_cnt = 0;
  logic [10:0] frame_q[$];
  logic [1:0]  stat_q[$];
  logic [9:0]  evt_q[$];

  always #5 clk = ~clk;

  assign ps2_clk_in  = dev_clk_hi & ~ps2_clk_drive_low;
  assign ps2_data_in = ~dev_data_low & ~ps2_data_drive_low;

  ps2_host_cmd_ctrl #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .MAX_RETRY(RTY)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_ready(cmd_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low),
    .rx_ready(rx_ready), .rx_code(rx_code),
    .evt_valid(evt_valid), .evt_code(evt_code),
    .done(done), .status(status), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitors: inhibit length, completions and forwarded events.
  always @(negedge clk) begin
    if (ps2_clk_drive_low) begin
      inh_cnt <= inh_cnt + 1;
      chk("both_low", 32'(ps2_data_drive_low), 32'd0);
    end else if (inh_cnt != 0) begin
      chk("inhibit_len", inh_cnt, INH);
      inh_cnt <= 0;
    end
    if (done) begin
      chk("done_expected", 32'(stat_q.size() != 0), 32'd1);
      if (stat_q.size() != 0) chk("status", 32'(status), 32'(stat_q.pop_front()));
    end
    if (evt_valid) begin
      chk("evt_expected", 32'(evt_q.size() != 0), 32'd1);
      if (evt_q.size() != 0) chk("evt_code", 32'(evt_code), 32'(evt_q.pop_front()));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(INH) + 100; i++) begin
      @(negedge clk);
      if (ps2_data_drive_low && !ps2_clk_drive_low) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("start_reached", 32'(ps2_data_drive_low), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    chk("idle_reached", 32'(cmd_ready), 32'd1);
    cyc(1);
  endtask

  // Device side: sample start bit, clock nedges falling edges, ACK on edge 11.
  task automatic dev_frame(input int nedges, input bit check);
    logic [10:0] bits;
    bits = '0;
    cyc(2);
    bits[0] = ps2_data_in;
    for (int k = 1; k <= nedges; k++) begin
      if (k == 11) dev_data_low = 1'b1;
      dev_clk_hi = 1'b0;
      cyc(HALF);
      if (k <= 10) bits[k] = ps2_data_in;
      dev_clk_hi = 1'b1;
      cyc(HALF);
      if (k == 11) dev_data_low = 1'b0;
    end
    if (check) begin
      chk("frame_expected", 32'(frame_q.size() != 0), 32'd1);
      if (frame_q.size() != 0) chk("frame", 32'(bits), 32'(frame_q.pop_front()));
    end
  endtask

  task automatic rx_pulse(input logic [9:0] code);
    rx_ready = 1'b1;
    rx_code  = code;
    cyc(1);
    rx_ready = 1'b0;
    cyc(2);
  endtask

  task automatic offer(input logic [7:0] b, input bit with_evt, input logic [9:0] ec);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_byte  = b;
    if (with_evt) begin
      rx_ready = 1'b1;
      rx_code  = ec;
      evt_q.push_back(ec);
    end
    cyc(1);
    cmd_valid = 1'b0;
    rx_ready  = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
  endtask

  task automatic one_tx(input logic [7:0] b, input logic [7:0] resp, input bit extra_evt);
    bit ok;
    frame_q.push_back({1'b1, ~^b, b, 1'b0});
    wait_start(ok);
    if (ok) begin
      dev_frame(11, 1'b1);
      if (extra_evt) rx_pulse(10'h21C);
      rx_pulse({2'b00, resp});
    end
  endtask

  initial begin
    bit ok;
    int k;

    rst_n = 1'b0;
    cyc(3);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_code", 32'(evt_code), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_clk_rel", 32'(ps2_clk_drive_low), 32'd0);
    chk("rst_data_rel", 32'(ps2_data_drive_low), 32'd0);
    rst_n = 1'b1;
    cyc(3);

    evt_q.push_back(10'h01C);
    rx_pulse(10'h01C);
    cyc(2);

    // 0xED with an event on the accept cycle and a stray event while awaiting the response.
    stat_q.push_back(2'b00);
    offer(8'hED, 1'b1, 10'h05A);
    one_tx(8'hED, 8'hFA, 1'b1);
    wait_idle();
    cyc(3);
    chk("status_held_ok", 32'(status), 32'd0);

    stat_q.push_back(2'b00);
    offer(8'hFF, 1'b0, '0);
    one_tx(8'hFF, 8'hFE, 1'b0);
    one_tx(8'hFF, 8'hFE, 1'b0);
    one_tx(8'hFF, 8'hFA, 1'b0);
    wait_idle();

    stat_q.push_back(2'b01);
    offer(8'hF4, 1'b0, '0);
    for (int i = 0; i <= int'(RTY); i++) one_tx(8'hF4, 8'hFE, 1'b0);
    wait_idle();
    cyc(3);
    chk("status_held_nak", 32'(status), 32'd1);

    stat_q.push_back(2'b10);
    offer(8'hF2, 1'b0, '0);
    wait_start(ok);
    k = 0;
    if (ok) begin
      for (int i = 0; i < int'(TMO) + 20; i++) begin
        @(negedge clk);
        k++;
        if (done) break;
      end
      chk("tmo_cycles", k, TMO);
      chk("tmo_clk_rel", 32'(ps2_clk_drive_low), 32'd0);
      chk("tmo_data_rel", 32'(ps2_data_drive_low), 32'd0);
    end
    wait_idle();

    // Reset mid-frame: lines must release without any clock edge and no completion follows.
    offer(8'hED, 1'b0, '0);
    wait_start(ok);
    if (ok) dev_frame(4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_clk_rel", 32'(ps2_clk_drive_low), 32'd0);
    chk("arst_data_rel", 32'(ps2_data_drive_low), 32'd0);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(60);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_status", 32'(status), 32'd0);

    chk("frames_left", frame_q.size(), 32'd0);
    chk("status_left", stat_q.size(), 32'd0);
    chk("events_left", evt_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    chk("global_timeout", 32'(cmd_ready), 32'hFFFF_FFFF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "FAIL global_timeout: simulation did not finish");
  end

endmodule
